// File: rtl/dino_pkg.sv
// Shared constants and FSM encoding for the dino button conditioner.
// Imported by the per-channel debouncer and by the top.
package dino_pkg;

  localparam int NCH_DEF       = 3;
  localparam int DB_CYCLES_DEF = 50000;

  localparam int CH_JUMP = 0;
  localparam int CH_HALT = 1;
  localparam int CH_DBG  = 2;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM with saturating counter, edge/toggle outputs.
// Latency: pad->level DB_CYCLES+2 edges, invert->level DB_CYCLES edges, bypass pad->level 3 edges.
module debounce_chan
  import dino_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic btn_in,
  input  logic cfg_invert,
  input  logic cfg_bypass,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_toggle
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1_q, s2_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          tog_q, tog_d;
  logic          c;
  logic          accept;

  assign c = s2_q ^ cfg_invert;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      tog_q   <= tog_d;
    end
  end

  // Bypass forces STABLE so dropping it mid-flight restarts a clean count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cfg_bypass) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (c != level_q) begin
            state_d = ST_COUNTING;
            cnt_d   = CW'(1);
          end
        end
        ST_COUNTING: begin
          if (c == level_q || cnt_q == CNT_LAST) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    accept  = (state_q == ST_COUNTING) && (c != level_q) && (cnt_q == CNT_LAST);
    level_d = level_q;
    if (cfg_bypass) begin
      level_d = c;
    end else if (accept) begin
      level_d = ~level_q;
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
    tog_d  = tog_q ^ rise_d;
  end

  assign btn_level  = level_q;
  assign btn_rise   = rise_q;
  assign btn_fall   = fall_q;
  assign btn_toggle = tog_q;

endmodule

// File: rtl/dino_input_cond.sv
// Button input conditioner: NCH independent synchronize/debounce/edge-detect channels.
// Latency per channel: pad->level DB_CYCLES+2 edges (3 in bypass); no backpressure.
module dino_input_cond
  import dino_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           sys_rst_n,
  input  logic [NCH-1:0] btn_in,
  input  logic [NCH-1:0] cfg_invert,
  input  logic           cfg_bypass,
  output logic [NCH-1:0] btn_level,
  output logic [NCH-1:0] btn_rise,
  output logic [NCH-1:0] btn_fall,
  output logic [NCH-1:0] btn_toggle
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    debounce_chan #(
      .DB_CYCLES (DB_CYCLES)
    ) u_chan (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .btn_in     (btn_in[g]),
      .cfg_invert (cfg_invert[g]),
      .cfg_bypass (cfg_bypass),
      .btn_level  (btn_level[g]),
      .btn_rise   (btn_rise[g]),
      .btn_fall   (btn_fall[g]),
      .btn_toggle (btn_toggle[g])
    );
  end

endmodule

// File: tb/tb_dino_input_cond.sv
// Directed bench for dino_input_cond with DB_CYCLES=8; edge events are scoreboarded
// against the absolute clock edge at which each must appear.
module tb_dino_input_cond;
  import dino_pkg::*;

  localparam int NCH = 3;
  localparam int DB  = 8;

  logic           clk = 1'b0;
  logic           sys_rst_n;
  logic [NCH-1:0] btn_in;
  logic [NCH-1:0] cfg_invert;
  logic           cfg_bypass;
  logic [NCH-1:0] btn_level;
  logic [NCH-1:0] btn_rise;
  logic [NCH-1:0] btn_fall;
  logic [NCH-1:0] btn_toggle;

  always #5 clk = ~clk;

  dino_input_cond #(
    .NCH       (NCH),
    .DB_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .btn_in     (btn_in),
    .cfg_invert (cfg_invert),
    .cfg_bypass (cfg_bypass),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .btn_toggle (btn_toggle)
  );

  typedef struct {
    int edge_no;
    int ch;
    bit rise;
    bit tog;
  } ev_t;

  ev_t            exp_q[$];
  ev_t            mon_e;
  int             checks = 0;
  int             errors = 0;
  int             cyc    = 0;
  bit [NCH-1:0]   tog_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pulse on channel ch, lat edges after the current negedge.
  task automatic push(input int ch, input bit rise, input int lat);
    ev_t e;
    if (rise) tog_m[ch] = ~tog_m[ch];
    e.edge_no = cyc + lat;
    e.ch      = ch;
    e.rise    = rise;
    e.tog     = tog_m[ch];
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sys_rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
        chk("missed_event_edge", cyc, exp_q[0].edge_no);
        void'(exp_q.pop_front());
      end
      for (int ch = 0; ch < NCH; ch++) begin
        chk("rise_and_fall", 32'(btn_rise[ch] & btn_fall[ch]), 0);
        if (btn_rise[ch] | btn_fall[ch]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {btn_rise[ch], btn_fall[ch]}, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("ev_edge", cyc, mon_e.edge_no);
            chk("ev_ch", ch, mon_e.ch);
            chk("ev_rise", 32'(btn_rise[ch]), 32'(mon_e.rise));
            chk("ev_level", 32'(btn_level[ch]), 32'(mon_e.rise));
            chk("ev_toggle", 32'(btn_toggle[ch]), 32'(mon_e.tog));
          end
        end
      end
    end
  end

  initial begin
    sys_rst_n  = 1'b1;
    btn_in     = '0;
    cfg_invert = '0;
    cfg_bypass = 1'b0;
    tog_m      = '0;
    #2 sys_rst_n = 1'b0;
    #1 chk("reset_outputs", {btn_level, btn_rise, btn_fall, btn_toggle}, 0);
    tick(3);
    sys_rst_n = 1'b1;

    // Idle: nothing may move.
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("idle_outputs", {btn_level, btn_rise, btn_fall, btn_toggle}, 0);
    end

    // Jump press: accepted on the 10th edge.
    tick(1);
    btn_in[CH_JUMP] = 1'b1;
    push(CH_JUMP, 1'b1, DB + 2);
    tick(9);
    chk("jump_lvl_e9", 32'(btn_level[0]), 0);
    tick(1);
    chk("jump_lvl_e10", 32'(btn_level[0]), 1);
    chk("jump_rise_e10", 32'(btn_rise[0]), 1);
    chk("jump_tog_1", 32'(btn_toggle[0]), 1);
    tick(1);
    chk("jump_rise_once", 32'(btn_rise[0]), 0);
    btn_in[CH_JUMP] = 1'b0;
    push(CH_JUMP, 1'b0, DB + 2);
    tick(12);
    chk("jump_lvl_release", 32'(btn_level[0]), 0);
    btn_in[CH_JUMP] = 1'b1;
    push(CH_JUMP, 1'b1, DB + 2);
    tick(12);
    chk("jump_lvl_2nd", 32'(btn_level[0]), 1);
    chk("jump_tog_0", 32'(btn_toggle[0]), 0);

    // Halt: 7-cycle glitch rejected, 8-cycle press accepted.
    btn_in[CH_HALT] = 1'b1;
    tick(7);
    btn_in[CH_HALT] = 1'b0;
    tick(14);
    chk("halt_glitch_lvl", 32'(btn_level[1]), 0);
    chk("halt_glitch_tog", 32'(btn_toggle[1]), 0);
    btn_in[CH_HALT] = 1'b1;
    push(CH_HALT, 1'b1, DB + 2);
    tick(8);
    btn_in[CH_HALT] = 1'b0;
    push(CH_HALT, 1'b0, DB + 2);
    tick(12);
    chk("halt_lvl_after", 32'(btn_level[1]), 0);
    chk("halt_tog", 32'(btn_toggle[1]), 1);

    // Debug: inversion alone produces a press after DB edges.
    cfg_invert[CH_DBG] = 1'b1;
    push(CH_DBG, 1'b1, DB);
    tick(7);
    chk("dbg_inv_lvl_e7", 32'(btn_level[2]), 0);
    tick(1);
    chk("dbg_inv_lvl_e8", 32'(btn_level[2]), 1);
    chk("dbg_inv_rise_e8", 32'(btn_rise[2]), 1);
    cfg_invert[CH_DBG] = 1'b0;
    push(CH_DBG, 1'b0, DB);
    tick(10);
    chk("dbg_inv_lvl_off", 32'(btn_level[2]), 0);

    // Bypass: one-cycle pad pulse shows up at edge 3 for one cycle.
    btn_in[CH_JUMP] = 1'b0;
    push(CH_JUMP, 1'b0, DB + 2);
    tick(12);
    chk("byp_pre_lvl", 32'(btn_level[0]), 0);
    cfg_bypass = 1'b1;
    tick(1);
    btn_in[CH_JUMP] = 1'b1;
    push(CH_JUMP, 1'b1, 3);
    push(CH_JUMP, 1'b0, 4);
    tick(1);
    btn_in[CH_JUMP] = 1'b0;
    tick(1);
    chk("byp_lvl_e2", 32'(btn_level[0]), 0);
    tick(1);
    chk("byp_lvl_e3", 32'(btn_level[0]), 1);
    chk("byp_rise_e3", 32'(btn_rise[0]), 1);
    tick(1);
    chk("byp_lvl_e4", 32'(btn_level[0]), 0);
    chk("byp_fall_e4", 32'(btn_fall[0]), 1);
    chk("byp_rise_e4", 32'(btn_rise[0]), 0);

    // Bypass asserted mid-count takes the level immediately.
    cfg_bypass = 1'b0;
    tick(1);
    btn_in[CH_JUMP] = 1'b1;
    tick(5);
    chk("abort_lvl_pre", 32'(btn_level[0]), 0);
    cfg_bypass = 1'b1;
    push(CH_JUMP, 1'b1, 1);
    tick(1);
    chk("abort_lvl_byp", 32'(btn_level[0]), 1);
    tick(2);
    cfg_bypass = 1'b0;
    btn_in[CH_JUMP] = 1'b0;
    push(CH_JUMP, 1'b0, DB + 2);
    tick(12);
    chk("abort_lvl_rel", 32'(btn_level[0]), 0);
    chk("pre_rst_toggles", 32'(btn_toggle), 32'h6);

    // Reset at counter=5 discards the partial count.
    btn_in[CH_JUMP] = 1'b1;
    tick(7);
    sys_rst_n = 1'b0;
    tog_m     = '0;
    #1 chk("midcount_rst_outputs", {btn_level, btn_rise, btn_fall, btn_toggle}, 0);
    tick(1);
    sys_rst_n = 1'b1;
    push(CH_JUMP, 1'b1, DB + 2);
    tick(9);
    chk("postrst_lvl_e9", 32'(btn_level[0]), 0);
    tick(1);
    chk("postrst_lvl_e10", 32'(btn_level[0]), 1);
    chk("postrst_rise_e10", 32'(btn_rise[0]), 1);
    chk("postrst_tog", 32'(btn_toggle[0]), 1);

    // Simultaneous presses on halt and debug.
    tick(1);
    btn_in[CH_HALT] = 1'b1;
    btn_in[CH_DBG]  = 1'b1;
    push(CH_HALT, 1'b1, DB + 2);
    push(CH_DBG, 1'b1, DB + 2);
    tick(12);
    chk("simul_levels", 32'(btn_level), 32'h7);

    tick(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
